freq_gate_ctrl: RTL and testbench

//  Measurement sequencer for the frequency counter; feeds the 4-digit display controller.

---
 rtl/freq_gate_ctrl_pkg.sv | 32 +++
 rtl/freq_gate_ctrl_sig_edge_sync.sv | 23 ++
 rtl/freq_gate_ctrl.sv | 135 +++++++++++++
 tb/tb_freq_gate_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gate_ctrl_pkg.sv
// Shared definitions for the frequency-counter gate sequencer: FSM states, count limits
// and the per-range gate-length table.
package freq_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_EVAL = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 14;
  localparam int unsigned TMR_W = 32;

  localparam logic [CNT_W-1:0] MAX_COUNT        = 14'd9999;
  localparam logic [CNT_W-1:0] CNT_SAT          = 14'd10000;  // overflow mark, one past MAX_COUNT
  localparam logic [CNT_W-1:0] DOWNRANGE_THRESH = 14'd1000;
  localparam logic [1:0]       MAX_RANGE        = 2'd3;

  // Gate length for range r is gate_cycles / 10**r.
  function automatic logic [TMR_W-1:0] gate_len(input logic [TMR_W-1:0] gate_cycles,
                                                input logic [1:0]       rng);
    logic [TMR_W-1:0] len;
    case (rng)
      2'd0:    len = gate_cycles;
      2'd1:    len = gate_cycles / 32'd10;
      2'd2:    len = gate_cycles / 32'd100;
      default: len = gate_cycles / 32'd1000;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_sig_edge_sync.sv
// Edge synchroniser (sig_edge_sync): two-flop synchroniser for the asynchronous signal
// under test plus a one-cycle rising-edge pulse.
module freq_gate_ctrl_sig_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic edge_pulse
);

  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], sig_in};

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  // Bits 0..1 form the synchroniser; bit 2 is the delayed copy for edge detection.
  assign edge_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency-counter measurement sequencer: timed gate, saturating edge count, auto-ranging
// and a stable result for the display. Define FREQ_HOLD_EN to add the hold input.
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
`ifdef FREQ_HOLD_EN
  input  logic        hold,
`endif
  input  logic        sig_in,
  output logic [15:0] displayed_number,
  output logic [1:0]  range,
  output logic        update,
  output logic        gate_active
);

  logic edge_pulse;
  logic hold_eff;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       cur_range_q, cur_range_d;
  logic [CNT_W-1:0] number_q, number_d;
  logic [1:0]       range_q, range_d;
  logic             update_q, update_d;
  logic             gate_active_q, gate_active_d;

  freq_gate_ctrl_sig_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

`ifdef FREQ_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d starts from its current value so no path through this block infers a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    count_d     = count_q;
    cur_range_d = cur_range_q;
    number_d    = number_q;
    range_d     = range_q;
    update_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_GATE;
          timer_d = gate_len(TMR_W'(GATE_CYCLES), cur_range_q) - 32'd1;
          count_d = '0;
        end
      end
      ST_GATE: begin
        if (edge_pulse && (count_q != CNT_SAT)) count_d = count_q + 14'd1;
        if (timer_q == '0) state_d = ST_EVAL;
        else               timer_d = timer_q - 32'd1;
      end
      ST_EVAL: begin
        state_d = ST_GATE;
        count_d = '0;
        if (count_q > MAX_COUNT) begin
          // Overflow: try a shorter gate; at the shortest gate show the clipped maximum.
          if (cur_range_q != MAX_RANGE) begin
            cur_range_d = cur_range_q + 2'd1;
          end else if (!hold_eff) begin
            number_d = MAX_COUNT;
            range_d  = cur_range_q;
            update_d = 1'b1;
          end
        end else begin
          if (!hold_eff) begin
            number_d = count_q;
            range_d  = cur_range_q;
            update_d = 1'b1;
          end
          if ((count_q < DOWNRANGE_THRESH) && (cur_range_q != 2'd0)) cur_range_d = cur_range_q - 2'd1;
        end
        timer_d = gate_len(TMR_W'(GATE_CYCLES), cur_range_d) - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable abandons the measurement but keeps the shown result and range.
    if (!enable) begin
      state_d     = ST_IDLE;
      timer_d     = timer_q;
      count_d     = count_q;
      cur_range_d = cur_range_q;
      number_d    = number_q;
      range_d     = range_q;
      update_d    = 1'b0;
    end

    gate_active_d = (state_d == ST_GATE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      count_q       <= '0;
      cur_range_q   <= '0;
      number_q      <= '0;
      range_q       <= '0;
      update_q      <= 1'b0;
      gate_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      cur_range_q   <= cur_range_d;
      number_q      <= number_d;
      range_q       <= range_d;
      update_q      <= update_d;
      gate_active_q <= gate_active_d;
    end
  end

  assign displayed_number = {2'b00, number_q};
  assign range            = range_q;
  assign update           = update_q;
  assign gate_active      = gate_active_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Randomised bench for freq_gate_ctrl: a window-based measurement model predicts every cycle
// and every published result; a monitor pops and compares whenever the DUT reports.
module tb_freq_gate_ctrl;

  localparam int GC = 25000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sig_in;
  logic        hold;
  logic [15:0] displayed_number;
  logic [1:0]  rng_o;
  logic        update;
  logic        gate_active;

  always #5 clk = ~clk;

  freq_gate_ctrl #(.GATE_CYCLES(GC)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
`ifdef FREQ_HOLD_EN
    .hold             (hold),
`endif
    .sig_in           (sig_in),
    .displayed_number (displayed_number),
    .range            (rng_o),
    .update           (update),
    .gate_active      (gate_active)
  );

  typedef struct {
    bit ga;
    bit upd;
    int num;
    int rng;
  } cyc_exp_t;

  typedef struct {
    int num;
    int rng;
  } res_t;

  cyc_exp_t cyc_q[$];
  res_t     res_q[$];
  cyc_exp_t e_mon;
  res_t     r_mon;

  int checks   = 0;
  int failures = 0;

  // Model state: sig_in level sampled at each clock edge, and the current gate window.
  bit s_hist [0:131071];
  int pe = 8;
  bit running = 1'b0;
  int gate_a  = 0;
  int eval_at = 0;
  int m_range = 0;
  int last_num = 0;
  int last_rng = 0;
  bit hold_lvl  = 1'b0;
  bit hold_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int glen(input int r);
    int l = GC;
    for (int i = 0; i < r; i++) l = l / 10;
    return l;
  endfunction

  // One model step for the clock edge about to happen with the given inputs.
  task automatic model_step(input bit en, input bit sg, input bit hd, input bit rst);
    int c;
    int prev_r;
    bit upd;
    upd = 1'b0;
    pe++;
    if (!rst) begin
      s_hist[pe] = 1'b0;
      running    = 1'b0;
      m_range    = 0;
      last_num   = 0;
      last_rng   = 0;
      cyc_q.delete();
      res_q.delete();
      return;
    end
    s_hist[pe] = sg;
    if (!running) begin
      if (en) begin
        running = 1'b1;
        gate_a  = pe + 1;
        eval_at = pe + 1 + glen(m_range);
      end
    end else if (!en) begin
      running = 1'b0;
    end else if (pe == eval_at) begin
      // An edge is counted on the gate clock edge two samples after sig_in was seen high.
      c = 0;
      for (int k = gate_a; k < pe; k++) if (s_hist[k-2] && !s_hist[k-3]) c++;
      prev_r = m_range;
      if (c > 9999) begin
        if (m_range < 3) m_range++;
        else if (!hd) begin
          last_num = 9999; last_rng = prev_r; upd = 1'b1;
          res_q.push_back(res_t'{9999, prev_r});
        end
      end else begin
        if (!hd) begin
          last_num = c; last_rng = prev_r; upd = 1'b1;
          res_q.push_back(res_t'{c, prev_r});
        end
        if (c < 1000 && m_range > 0) m_range--;
      end
      gate_a  = pe + 1;
      eval_at = pe + 1 + glen(m_range);
    end
    cyc_q.push_back(cyc_exp_t'{running && (pe + 1 < eval_at), upd, last_num, last_rng});
  endtask

  task automatic run_cycle(input bit en, input bit sg, input bit rst);
    @(negedge clk);
    enable = en;
    sig_in = sg;
    hold   = hold_lvl;
    reset  = rst;
    model_step(en, sg, hold_lvl, rst);
  endtask

  // period > 0: square wave with random phase; period == 0: random short runs (mean 2.25 clk).
  task automatic run_sig(input int cycles, input int period, input bit en);
    bit lvl;
    int left;
    int ph;
    lvl  = 1'b0;
    left = 1;
    ph   = 0;
    if (period > 0) ph = int'($urandom_range(period - 1));
    for (int i = 0; i < cycles; i++) begin
      if (period > 0) begin
        lvl = (((i + ph) % period) < (period / 2));
      end else begin
        left--;
        if (left == 0) begin
          lvl  = ~lvl;
          left = lvl ? 1 : (($urandom_range(3) == 0) ? 2 : 1);
        end
      end
`ifdef FREQ_HOLD_EN
      if (hold_rand) hold_lvl = ($urandom_range(3) == 0);
`endif
      run_cycle(en, lvl, 1'b1);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset === 1'b1 && cyc_q.size() > 0) begin
      e_mon = cyc_q.pop_front();
      check("gate_active", gate_active, e_mon.ga);
      check("update", update, e_mon.upd);
      check("displayed_number", displayed_number, e_mon.num);
      check("range", rng_o, e_mon.rng);
      if (update === 1'b1) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result_queue: got update=1 expected no update (no result pending) at %0t", $time);
        end else begin
          r_mon = res_q.pop_front();
          check("result_number", displayed_number, r_mon.num);
          check("result_range", rng_o, r_mon.rng);
        end
      end
    end
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    hold   = 1'b0;
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0);
    check("rst_displayed_number", displayed_number, 0);
    check("rst_range", rng_o, 0);
    check("rst_update", update, 0);
    check("rst_gate_active", gate_active, 0);

    // Fast signal overflows the long gate and forces an up-range.
    run_sig(25010, 2, 1'b1);

    // Dense random runs in range 1; optional random hold around evaluations.
`ifdef FREQ_HOLD_EN
    hold_rand = 1'b1;
`endif
    run_sig(5000, 0, 1'b1);
    hold_rand = 1'b0;
    hold_lvl  = 1'b0;
    run_sig(1250, 0, 1'b1);

    // Abort around mid-gate, then resume in the retained range.
    run_sig(5, 0, 1'b0);
    run_sig(5000, 0, 1'b1);

    // Slower signal: low count down-ranges, then a full long gate.
    run_sig(31000, 10, 1'b1);

    // Asynchronous reset in the middle of a gate.
    run_sig(400, 0, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midgate_rst_displayed_number", displayed_number, 0);
    check("midgate_rst_range", rng_o, 0);
    check("midgate_rst_update", update, 0);
    check("midgate_rst_gate_active", gate_active, 0);
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0);
    run_sig(300, 7, 1'b1);
    run_sig(5, 0, 1'b0);

    @(posedge clk);
    #2;
    check("pending_results", res_q.size(), 0);
    check("final_displayed_number", displayed_number, last_num);
    check("final_gate_active", gate_active, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
